// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and default width.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    // Partial remainder stays below the divisor, so bit WIDTH of diff is the borrow.
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle, with flush.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntInit = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    a_mag   = (signed_div && a[WIDTH-1]) ? -a : a;
    b_mag   = (signed_div && b[WIDTH-1]) ? -b : b;
    quo_fix = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
    rem_fix = sign_a_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !annul) begin
            if (b == '0) begin
              quotient_q  <= '1;
              remainder_q <= a;
              state_q     <= S_DONE;
            end else begin
              rem_q    <= '0;
              quo_q    <= a_mag;
              div_q    <= b_mag;
              sign_a_q <= signed_div & a[WIDTH-1];
              sign_b_q <= signed_div & b[WIDTH-1];
              cnt_q    <= CntInit;
              state_q  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - CntOne;
            if (cnt_q == CntOne) begin
              quotient_q  <= quo_fix;
              remainder_q <= rem_fix;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign done      = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model plus hand-computed vectors.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, sgn, annul;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] quo, rem;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (sgn),
    .annul      (annul),
    .a          (a_in),
    .b          (b_in),
    .busy       (busy),
    .done       (done),
    .quotient   (quo),
    .remainder  (rem)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain operators, with divide-by-zero and overflow rules.
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  function automatic res_t model_div(input logic [31:0] x, input logic [31:0] y,
                                     input logic s);
    res_t res;
    if (y == 32'd0) begin
      res.q = 32'hFFFF_FFFF;
      res.r = x;
    end else if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        res.q = 32'h8000_0000;
        res.r = 32'd0;
      end else begin
        res.q = $signed(x) / $signed(y);
        res.r = $signed(x) % $signed(y);
      end
    end else begin
      res.q = x / y;
      res.r = x % y;
    end
    return res;
  endfunction

  res_t        nres, pres;
  logic        m_busy, m_done;
  logic [31:0] m_q, m_r;
  int          m_left;

  assign nres = model_div(a_in, b_in, sgn);

  // Cycle-level expectation: result appears WIDTH+1 cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (annul) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= pres.q;
        m_r    <= pres.r;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start && !annul) begin
      if (b_in == 32'd0) begin
        m_done <= 1'b1;
        m_q    <= nres.q;
        m_r    <= nres.r;
      end else begin
        m_busy <= 1'b1;
        m_left <= 32;
        pres   <= nres;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("quotient", quo, m_q);
      check("remainder", rem, m_r);
      check("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic s,
                     output int cyc);
    a_in  = x;
    b_in  = y;
    sgn   = s;
    start = 1'b1;
    cyc   = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!done && cyc < 100);
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic op(input string name, input logic [31:0] x, input logic [31:0] y,
                    input logic s, input int exp_cyc, input logic [31:0] eq,
                    input logic [31:0] er);
    int c;
    run(x, y, s, c);
    check({name, "_cycles"}, 32'(c), 32'(exp_cyc));
    check({name, "_q"}, quo, eq);
    check({name, "_r"}, rem, er);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    bit seen;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_q", quo, 32'd0);
    check("reset_r", rem, 32'd0);

    op("u100_7",   32'd100,       32'd7,         1'b0, 33, 32'd14,        32'd2);
    op("s_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0);
    op("s_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1);
    op("s_m7_m2",  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 33, 32'd3,         32'hFFFF_FFFF);
    op("u_big_2",  32'hFFFF_FFF9, 32'd2,         1'b0, 33, 32'h7FFF_FFFC, 32'd1);
    op("div0",     32'h1234_5678, 32'd0,         1'b0, 1,  32'hFFFF_FFFF, 32'h1234_5678);

    // Flush at step 10: no result, outputs keep the divide-by-zero values.
    a_in = 32'd1000; b_in = 32'd3; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("annul_no_done", 32'(seen), 32'd0);
    check("annul_q_hold", quo, 32'hFFFF_FFFF);
    check("annul_r_hold", rem, 32'h1234_5678);
    op("after_annul", 32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1);

    // Reset at step 5 discards the operation and clears the results.
    a_in = 32'hDEAD_BEEF; b_in = 32'h1234; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", quo, 32'd0);
    check("rst_r", rem, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rst_no_done", 32'(seen), 32'd0);

    // Starts during BUSY and DONE must be ignored.
    a_in = 32'd20000; b_in = 32'd7; sgn = 1'b0; start = 1'b1; c = 0;
    do begin
      @(negedge clk);
      c++;
      start = (c == 5 || c == 20);
      if (start) begin
        a_in = 32'd9;
        b_in = 32'd0;
      end
    end while (!done && c < 100);
    check("ign_done_seen", 32'(done), 32'd1);
    check("ign_cycles", 32'(c), 32'd33);
    check("ign_q", quo, 32'd2857);
    check("ign_r", rem, 32'd1);
    a_in = 32'd50; b_in = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_done_start_busy", 32'(busy), 32'd0);
    check("ign_done_start_done", 32'(done), 32'd0);

    // Annul together with start in IDLE wins.
    a_in = 32'd50; b_in = 32'd5; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check("idle_annul_busy", 32'(busy), 32'd0);
    check("idle_annul_done", 32'(done), 32'd0);

    op("s_div0", 32'hFFFF_FFF9, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request a division; accepted only in IDLE.
REQ-005 Port: signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 Port: annul  input  1  flush; aborts any in-flight operation.
REQ-007 Port: a  input  WIDTH  dividend; sampled with start.
REQ-008 Port: b  input  WIDTH  divisor; sampled with start.
REQ-009 Port: busy  output  1  high while a division is iterating; the pipeline stalls on it.
REQ-010 Port: done  output  1  one-cycle pulse; results valid in that cycle.
REQ-011 Port: quotient  output  WIDTH  result, feeds the writeback-select mux (HI/LO path).
REQ-012 Port: remainder  output  WIDTH  result, feeds the writeback-select mux (HI/LO path).

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 IDLE, start=1, annul=0, b!=0: the block SHALL latch |a| and |b| (magnitudes taken only when signed_div=1), both sign bits and counter=WIDTH, then go to BUSY.
REQ-015 IDLE, start=1, annul=0, b==0: the block SHALL go directly to DONE with quotient = all ones and remainder = a.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle and decrement the counter.
REQ-017 BUSY SHALL go to DONE after exactly WIDTH steps; done SHALL be high in cycle WIDTH+1 after the accepting edge.
REQ-018 DONE SHALL hold done=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-019 start SHALL be ignored in BUSY and DONE; a new start is accepted only in IDLE.
REQ-020 busy SHALL be 1 only in BUSY; done SHALL be 1 only in DONE; busy and done are never high together.
REQ-021 Signed sign fix-up SHALL be applied on entry to DONE:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
REQ-023 quotient and remainder SHALL update only on entry to DONE and hold until the next completed operation.
REQ-024 annul=1 in BUSY or DONE SHALL force IDLE on the next edge, suppress done, and leave the outputs at their previous values.
REQ-025 annul=1 together with start=1 in IDLE SHALL cause start to be ignored.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, quotient=0, remainder=0 and all internal registers cleared.
REQ-027 rst SHALL take priority over start and annul; a reset during BUSY discards the operation and no done is produced.

Structure
REQ-028 A shared package SHALL hold:
- state encodings S_IDLE=2'b00, S_BUSY=2'b01, S_DONE=2'b10;
- the DIV_WIDTH default of 32.
REQ-029 One combinational sub-module, div_step, SHALL implement a single restoring iteration; div_unit instantiates it once.

Verification
REQ-030 Unsigned 100/7: start at cycle 0 -> done at cycle 33, quotient=14, remainder=2.
REQ-031 Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-033 Divide by zero, a=0x12345678, b=0 -> done at cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678.
REQ-034 annul at BUSY step 10 -> busy=0 next cycle, no done, outputs unchanged; the next start completes normally.
REQ-035 Two checks:
- rst at BUSY step 5 -> IDLE with outputs 0;
- start pulses while BUSY -> ignored, and the first result is unaffected.
